switch_debouncer: RTL and testbench
===================================

SWITCH_DEBOUNCER -- requirements
Module: switch_debouncer

Interface
REQ-001 Parameter N_SW, default 5: number of switch channels.
REQ-002 Parameter CNT_MAX, default 500000: consecutive stable cycles needed to accept a new level (5 ms at 100 MHz); legal range 2..2^20.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 sw_raw  input  N_SW  raw, asynchronous, bouncing slide-switch levels.
REQ-006 sw_db  output  N_SW  debounced switch levels; drives the gate/mux selection stage directly (bit 0 and bit 1 are operands, bits 4:2 are the select).
REQ-007 sw_rise  output  N_SW  one-cycle pulse per channel when sw_db goes 0->1.
REQ-008 sw_fall  output  N_SW  one-cycle pulse per channel when sw_db goes 1->0.
REQ-009 sw_chg  output  1  one-cycle pulse, OR of all sw_rise and sw_fall bits in the same cycle.

Function
REQ-010 Each channel is independent; no cross-channel state is shared except sw_chg.
REQ-011 Each channel passes sw_raw through a two-flop synchronizer (sync1, sync2) before any other logic.
REQ-012 Each channel holds a two-state FSM: STABLE (sync2 == sw_db) and PENDING (sync2 != sw_db).
REQ-013 STABLE: counter held at 0; on sync2 != sw_db, go to PENDING with counter = 1.
REQ-014 PENDING: while sync2 != sw_db, counter increments by 1 per cycle.
REQ-015 PENDING, sync2 returns to sw_db before acceptance (bounce): counter cleared to 0, go to STABLE, sw_db unchanged, no pulse.
REQ-016 PENDING, counter == CNT_MAX and sync2 still != sw_db: sw_db <= sync2, counter <= 0, go to STABLE, matching rise/fall pulse in the same cycle sw_db updates.
REQ-017 Latency: a clean raw level change sampled at edge t appears on sw_db after edge t+2+CNT_MAX; any earlier reversal restarts the count per REQ-015.
REQ-018 Counter width is ceil(log2(CNT_MAX+1)) bits; the counter never wraps, since acceptance at CNT_MAX clears it.
REQ-019 sw_rise, sw_fall and sw_chg are registered and high for exactly one cycle per accepted transition.
REQ-020 Simultaneous acceptance on several channels in one cycle: each sets its own rise/fall bit, and sw_chg is a single one-cycle pulse.
REQ-021 A raw pulse shorter than CNT_MAX+1 sync2 cycles never changes sw_db.

Reset
REQ-022 On rst_n low, asynchronously: sync1, sync2, sw_db, sw_rise, sw_fall and sw_chg go to 0, counters go to 0, and every FSM goes to STABLE.
REQ-023 Reset asserted mid-PENDING discards the pending transition; after release, a raw input held high is re-accepted via the full REQ-017 latency.
REQ-024 Reset deassertion is synchronized by the top level; this block only requires rst_n release to meet clk recovery timing.

Structure
REQ-025 Shared package switch_pkg holds N_SW default, CNT_MAX default, the sim-override value CNT_MAX_SIM = 4, and the STABLE/PENDING state encoding (1 bit).
REQ-026 One sub-module, debounce_bit (synchronizer + FSM + counter + edge pulses for one channel), instantiated N_SW times by generate; switch_debouncer adds only the sw_chg OR-reduction and its register.

Verification (CNT_MAX = 4)
REQ-027 Reset: rst_n=0 with sw_raw=5'b11111 -> all outputs 0 throughout; after release with input held, sw_db=5'b11111 exactly 6 edges later, sw_rise=5'b11111 and sw_chg=1 for one cycle.
REQ-028 Clean edge: sw_raw[0] 0->1 sampled at edge t -> sw_db[0]=1 after edge t+6, sw_rise[0] high for that single cycle only.
REQ-029 Bounce: sw_raw[2] toggles 1,0,1,0 on consecutive cycles, then holds 1 -> no pulse during the toggling; sw_db[2]=1 six edges after the final rise.
REQ-030 Glitch: sw_raw[4] high for 3 cycles then low -> sw_db[4] stays 0, sw_chg never pulses.
REQ-031 Simultaneous: sw_raw[1]=1 and sw_raw[3]=1 on the same edge -> sw_rise=5'b01010 and a single sw_chg pulse in one cycle.
REQ-032 Reset mid-PENDING: rst_n low 3 cycles after a raw change, then released with raw held -> sw_db updates only after a full 6-edge latency from release; no pulse before that.

Source files
------------

// File: rtl/switch_pkg.sv
// switch_pkg: shared constants and state encoding for the switch debouncer.
//   N_SW_DEF     - default number of switch channels
//   CNT_MAX_DEF  - default stable-cycle count (5 ms at 100 MHz)
//   CNT_MAX_SIM  - short count used for simulation builds
//   db_state_e   - per-channel FSM state (1 bit)
package switch_pkg;

  localparam int N_SW_DEF    = 5;
  localparam int CNT_MAX_DEF = 500000;
  localparam int CNT_MAX_SIM = 4;

  typedef enum logic {
    ST_STABLE  = 1'b0,  // synchronized input agrees with the debounced level
    ST_PENDING = 1'b1   // synchronized input disagrees; counting stable cycles
  } db_state_e;

endpackage

// File: rtl/debounce_bit.sv
// debounce_bit: one debounce channel.
// A two-flop synchronizer feeds a STABLE/PENDING FSM with a stability counter.
// A new level is accepted only after CNT_MAX consecutive disagreeing cycles.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   raw         - raw asynchronous switch level
//   db          - debounced level (registered)
//   rise, fall  - registered one-cycle pulses on accepted 0->1 / 1->0
//   edge_nxt    - combinational "a pulse is being loaded this cycle"; lets the
//                 parent register a channel-OR aligned with rise/fall
//   state       - current FSM state, for observation
module debounce_bit
  import switch_pkg::*;
#(
  parameter int CNT_MAX = CNT_MAX_DEF
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      raw,
  output logic      db,
  output logic      rise,
  output logic      fall,
  output logic      edge_nxt,
  output db_state_e state
);

  localparam int CW = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          sync1_q, sync2_q;
  db_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          db_q, db_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= ST_STABLE;
      cnt_q   <= '0;
      db_q    <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    db_d    = db_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      ST_STABLE: begin
        cnt_d = '0;
        if (sync2_q != db_q) begin
          state_d = ST_PENDING;
          cnt_d   = CNT_ONE;
        end
      end
      ST_PENDING: begin
        if (sync2_q == db_q) begin
          // Bounce back before acceptance: drop the candidate silently.
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          // Accept; clearing here is what keeps the counter from wrapping.
          state_d = ST_STABLE;
          cnt_d   = '0;
          db_d    = sync2_q;
          rise_d  = sync2_q;
          fall_d  = ~sync2_q;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign db       = db_q;
  assign rise     = rise_q;
  assign fall     = fall_q;
  assign edge_nxt = rise_d | fall_d;
  assign state    = state_q;

endmodule

// File: rtl/switch_debouncer.sv
// switch_debouncer: N_SW independent debounced slide switches.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   sw_raw     - raw bouncing switch levels
//   sw_db      - debounced levels (bits 1:0 operands, bits 4:2 select downstream)
//   sw_rise    - one-cycle pulse per channel on accepted 0->1
//   sw_fall    - one-cycle pulse per channel on accepted 1->0
//   sw_chg     - one-cycle pulse when any channel pulses rise or fall
//   sw_state   - per-channel FSM state (1 = PENDING), for observation
module switch_debouncer
  import switch_pkg::*;
#(
  parameter int N_SW    = N_SW_DEF,
  parameter int CNT_MAX = CNT_MAX_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_SW-1:0] sw_raw,
  output logic [N_SW-1:0] sw_db,
  output logic [N_SW-1:0] sw_rise,
  output logic [N_SW-1:0] sw_fall,
  output logic            sw_chg,
  output logic [N_SW-1:0] sw_state
);

  logic [N_SW-1:0] edge_nxt;
  logic            sw_chg_q, sw_chg_d;

  for (genvar i = 0; i < N_SW; i++) begin : g_ch
    db_state_e st;
    debounce_bit #(
      .CNT_MAX(CNT_MAX)
    ) u_bit (
      .clk     (clk),
      .rst_n   (rst_n),
      .raw     (sw_raw[i]),
      .db      (sw_db[i]),
      .rise    (sw_rise[i]),
      .fall    (sw_fall[i]),
      .edge_nxt(edge_nxt[i]),
      .state   (st)
    );
    assign sw_state[i] = (st == ST_PENDING);
  end

  // OR the next-cycle pulse values so sw_chg lands in the same cycle as
  // the registered rise/fall bits rather than one cycle after.
  always_comb begin
    sw_chg_d = |edge_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sw_chg_q <= 1'b0;
    else        sw_chg_q <= sw_chg_d;
  end

  assign sw_chg = sw_chg_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// tb_switch_debouncer: directed bench for switch_debouncer with CNT_MAX = 4.
// Expected output words {sw_db, sw_rise, sw_fall, sw_chg} are queued with the
// cycle they must appear in; a negedge monitor pops and compares them, and in
// every other cycle requires the held level with no pulses.
module tb_switch_debouncer;
  import switch_pkg::*;

  localparam int N  = 5;
  localparam int LAT = CNT_MAX_SIM + 2;  // edges from sampling to sw_db update
  localparam int OW = 3 * N + 1;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] sw_raw;
  logic [N-1:0] sw_db, sw_rise, sw_fall, sw_state;
  logic         sw_chg;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit mon_en = 0;

  logic [OW-1:0] exp_q[$];
  int            exp_cyc_q[$];
  logic [N-1:0]  planned_db;  // level the bench has scheduled most recently
  logic [N-1:0]  model_db;    // level the monitor currently expects

  switch_debouncer #(
    .N_SW   (N),
    .CNT_MAX(CNT_MAX_SIM)
  ) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sw_raw  (sw_raw),
    .sw_db   (sw_db),
    .sw_rise (sw_rise),
    .sw_fall (sw_fall),
    .sw_chg  (sw_chg),
    .sw_state(sw_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, expv);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!mon_en) begin
      model_db = '0;
    end else if (exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc) begin
      logic [OW-1:0] e;
      e = exp_q.pop_front();
      void'(exp_cyc_q.pop_front());
      chk("accept", 32'({sw_db, sw_rise, sw_fall, sw_chg}), 32'(e));
      model_db = e[OW-1 -: N];
    end else begin
      if (exp_cyc_q.size() > 0 && exp_cyc_q[0] < cyc) begin
        chk("missed_slot", 32'(cyc), 32'(exp_cyc_q[0]));
        void'(exp_q.pop_front());
        void'(exp_cyc_q.pop_front());
      end
      chk("hold", 32'({sw_db, sw_rise, sw_fall, sw_chg}), 32'({model_db, {(OW-N){1'b0}}}));
    end
  end

  // driver tasks
  task automatic drive(input logic [N-1:0] v);
    @(negedge clk);
    #1;
    sw_raw = v;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called right after drive: the change is sampled at edge cyc+1.
  task automatic sched(input logic [N-1:0] new_db);
    logic [N-1:0] r, f;
    r = new_db & ~planned_db;
    f = ~new_db & planned_db;
    exp_q.push_back({new_db, r, f, |(r | f)});
    exp_cyc_q.push_back(cyc + 1 + LAT);
    planned_db = new_db;
  endtask

  task automatic reset_window(input int n);
    repeat (n) begin
      @(negedge clk);
      chk("in_reset", 32'({sw_db, sw_rise, sw_fall, sw_chg}), 32'(0));
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    #1;
    rst_n      = 1'b1;
    mon_en     = 1'b1;
    planned_db = '0;
  endtask

  initial begin
    rst_n      = 1'b0;
    sw_raw     = 5'b11111;
    planned_db = '0;

    // Reset with all inputs high: outputs stay 0, then full-latency accept.
    reset_window(4);
    release_reset();
    sched(5'b11111);
    idle(12);

    // All channels fall together.
    drive(5'b00000);
    sched(5'b00000);
    idle(12);

    // Clean rise on channel 0.
    drive(5'b00001);
    sched(5'b00001);
    idle(12);

    // Bounce on channel 2, then settle high.
    drive(5'b00101);
    drive(5'b00001);
    drive(5'b00101);
    drive(5'b00001);
    drive(5'b00101);
    sched(5'b00101);
    idle(12);

    // Glitch on channel 4 for three cycles: nothing may change.
    drive(5'b10101);
    idle(2);
    drive(5'b00101);
    idle(12);

    // Channels 1 and 3 rise on the same edge.
    drive(5'b01111);
    sched(5'b01111);
    idle(12);

    // Channel 0 falls, reset lands mid-PENDING; afterwards the held raw
    // level is re-accepted from zero with the full latency.
    drive(5'b01110);
    idle(3);
    #1;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    chk("queue_before_reset", 32'(exp_q.size()), 32'(0));
    reset_window(3);
    release_reset();
    sched(5'b01110);
    idle(14);

    // Random stable levels, each held long enough to be accepted.
    for (int k = 0; k < 6; k++) begin
      logic [N-1:0] v;
      v = N'($urandom_range(0, (1 << N) - 1));
      drive(v);
      if (v != planned_db) sched(v);
      idle(10);
    end

    chk("queue_drained", 32'(exp_q.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
